// File: rtl/golden_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : golden_serializer                                             |
// | Purpose  : Parallel-to-serial transmitter for BIST golden response words.|
// |            Shifts one WIDTH-bit word out one bit per unstalled cycle,    |
// |            strobes shift_en for each new bit and counts sent frames.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module golden_serializer #(
  parameter int WIDTH       = 64,
  parameter int CNT_W       = 7,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [WIDTH-1:0]       load_data,
  input  logic                   stall,
  output logic                   serial_out,
  output logic                   shift_en,
  output logic                   busy,
  output logic                   done,
  output logic [FRAME_CNT_W-1:0] frames_sent
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic             next_bit;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;

  // The bit about to leave is always at the transmit end of the shift
  // register; the register moves toward that end after each emitted bit.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign next_bit      = shreg[WIDTH-1];
      assign shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign next_bit      = shreg[0];
      assign shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
    end
  endgenerate

  // Counter holds the index of the bit about to be emitted.
  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    state_next = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (!stall && last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: capture, shift, strobe, completion pulse and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      serial_out  <= 1'b0;
      shift_en    <= 1'b0;
      done        <= 1'b0;
      frames_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          shift_en <= 1'b0;
          done     <= 1'b0;
          if (load_valid) begin
            shreg   <= load_data;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          done <= 1'b0;
          if (stall) begin
            shift_en <= 1'b0;
          end else begin
            serial_out <= next_bit;
            shift_en   <= 1'b1;
            shreg      <= shreg_shifted;
            bit_cnt    <= bit_cnt + 1'b1;
          end
        end
        DONE: begin
          // Stall is deliberately ignored here: the frame is already complete.
          shift_en    <= 1'b0;
          done        <= 1'b1;
          frames_sent <= frames_sent + 1'b1;
        end
        default: begin
          shift_en <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/golden_serializer.md
Name: golden_serializer

Overview:
Parallel-to-serial transmitter feeding the BIST wrapper register's serial input. It accepts one WIDTH-bit golden response word from the BIST controller and shifts it out one bit per enabled clock on serial_out. A qualifying shift_en strobe gates the receiver's shift clock. It also counts frames sent so the controller can pace MISR compaction.

Parameters:
WIDTH, 64, bits per frame; must be >= 2
CNT_W, 7, bit-counter width; must satisfy 2^CNT_W > WIDTH
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first
FRAME_CNT_W, 16, width of frames_sent counter

Ports:
clk  input  1  single system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
load_valid  input  1  load_data is valid
load_ready  output  1  block can accept a word
load_data  input  WIDTH  golden word to transmit
stall  input  1  freezes shifting while high
serial_out  output  1  serial data to wrapper register serial_in
shift_en  output  1  high for exactly the cycles in which serial_out carries a new bit
busy  output  1  a frame is in flight
done  output  1  one-cycle pulse after the last bit
frames_sent  output  FRAME_CNT_W  completed-frame count; wraps

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. No asynchronous reset.
- Reset values:
  - serial_out=0, shift_en=0, busy=0, done=0, frames_sent=0.
  - load_ready=1; state=IDLE; bit counter=0; shift register=0.
- rst high at any time, including mid-frame, aborts the frame. All outputs take their reset values at that edge.
- States:
  - IDLE: load_ready=1, busy=0.
  - SHIFT: load_ready=0, busy=1.
  - DONE: load_ready=0, busy=1.
- IDLE to SHIFT: at the edge where load_valid&&load_ready.
  - load_data is captured into the shift register.
  - The bit counter is cleared.
  - shift_en stays 0 on this edge.
- SHIFT, on each edge with stall=0:
  - serial_out<=next bit (MSB or LSB end per MSB_FIRST) and shift_en<=1.
  - The shift register shifts by one; the counter increments.
- SHIFT, on an edge with stall=1:
  - shift_en<=0; serial_out, counter and shift register hold.
- SHIFT to DONE: on the edge that emits bit number WIDTH (counter reaches WIDTH-1 before increment).
- DONE, next edge (stall ignored):
  - shift_en<=0, done<=1.
  - frames_sent<=frames_sent+1, wrapping modulo 2^FRAME_CNT_W.
  - state<=IDLE.
- Next edge after that: done<=0.
- Latency: acceptance at edge N.
  - With no stall, bits appear after edges N+1..N+WIDTH.
  - done is high after edge N+WIDTH+1.
  - load_ready returns after edge N+WIDTH+1.
  - Minimum frame-to-frame period is WIDTH+2 cycles.
- load_valid while load_ready=0 is ignored; the word is not queued.
- serial_out holds its last value after the frame. It is only meaningful while shift_en=1.
- Exactly WIDTH shift_en pulses per frame, regardless of stall pattern.
- stall asserted in IDLE has no effect on acceptance.

Test Plan:
- Reset then idle, no load: load_ready=1, busy=0, shift_en=0, serial_out=0, frames_sent=0 for 10 cycles.
- Load 64'h8000_0000_0000_0001, MSB_FIRST=1, stall=0, accepted at edge N:
  - Response timing: shift_en=1 for edges N+1..N+64.
  - Response data: serial_out=1 at N+1, 0 for N+2..N+63, 1 at N+64.
  - Response completion: done pulse at N+65 only; frames_sent=1.
- Same word with MSB_FIRST=0: first and last bits are 1 and the middle bits are 0. A companion word 64'h0000_0000_0000_0003 must yield 1,1 then 62 zeros.
- Stall 3 cycles after the 10th bit of 64'hA5A5_A5A5_A5A5_A5A5:
  - Exactly 64 shift_en pulses, with the bit sequence unbroken.
  - done at N+68.
- load_valid pulses mid-frame are ignored: the frame completes unchanged and frames_sent increments by 1.
- rst asserted at bit 30: all outputs return to reset values at that edge. A new load then transmits a full 64-bit frame with frames_sent=1.
